// File: rtl/recarga_pkg.sv
// Shared types, sizing constants and the load-clipping helper for the top-up kiosk.
package recarga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLETA  = 2'd1,
    CARREGA = 2'd2,
    TROCO   = 2'd3
  } estado_t;

  localparam int unsigned CRED_W  = 2;
  localparam int unsigned SALDO_W = 3;

  localparam logic [CRED_W-1:0]  MAX_CREDITO    = 2'd3;
  localparam logic [SALDO_W-1:0] SALDO_MAX      = 3'd5;
  localparam int unsigned        TIMEOUT_CICLOS = 10;

  // Largest load that fits on the card; balances above the ceiling count as full.
  function automatic logic [CRED_W-1:0] min_carga(input logic [CRED_W-1:0]  credito,
                                                   input logic [SALDO_W-1:0] saldo);
    logic [SALDO_W-1:0] sat;
    logic [SALDO_W-1:0] espaco;
    sat    = (saldo > SALDO_MAX) ? SALDO_MAX : saldo;
    espaco = SALDO_MAX - sat;
    if (SALDO_W'(credito) <= espaco) begin
      return credito;
    end else begin
      return espaco[CRED_W-1:0];
    end
  endfunction

endpackage

// File: rtl/recarga_terminal_if.sv
// Kiosk <-> fare controller signal bundle; the kiosk uses the slave modport.
interface recarga_terminal_if;
  import recarga_pkg::*;

  logic               moeda;
  logic               sel_passageiro;
  logic               confirma;
  logic               cancela;
  logic [SALDO_W-1:0] saldo1;
  logic [SALDO_W-1:0] saldo2;
  logic [CRED_W-1:0]  carrega1;
  logic [CRED_W-1:0]  carrega2;
  logic               devolve;
  logic [CRED_W-1:0]  credito;
  logic               rejeita;
  logic               ocupado;

  modport master (
    output moeda, sel_passageiro, confirma, cancela, saldo1, saldo2,
    input  carrega1, carrega2, devolve, credito, rejeita, ocupado
  );

  modport slave (
    input  moeda, sel_passageiro, confirma, cancela, saldo1, saldo2,
    output carrega1, carrega2, devolve, credito, rejeita, ocupado
  );

endinterface

// File: rtl/recarga_timer.sv
// Inactivity counter for COLETA: expira_o flags the CICLOS-th consecutive idle cycle.
module recarga_timer #(
  parameter int unsigned CICLOS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic ativo_i,
  input  logic evento_i,
  output logic expira_o
);

  localparam int unsigned CW = $clog2(CICLOS + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count idle cycles while collecting; any activity or leaving COLETA restarts it.
  always_comb begin
    cnt_d    = cnt_q;
    expira_o = 1'b0;
    if (!ativo_i || evento_i) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CICLOS - 1)) begin
      expira_o = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/recarga_terminal.sv
// Card top-up kiosk: coin collection, clipped card load, coin-by-coin refund.
// Optional inactivity cancel in COLETA is enabled with RECARGA_TIMEOUT_EN.
module recarga_terminal
  import recarga_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  recarga_terminal_if.slave bus
);

  estado_t           estado_q,   estado_d;
  logic [CRED_W-1:0] credito_q,  credito_d;
  logic [CRED_W-1:0] refund_q,   refund_d;
  logic [CRED_W-1:0] carrega1_q, carrega1_d;
  logic [CRED_W-1:0] carrega2_q, carrega2_d;
  logic              devolve_q,  devolve_d;
  logic              rejeita_q,  rejeita_d;
  logic              ocupado_q,  ocupado_d;

  logic [SALDO_W-1:0] saldo_sel_s;
  logic [CRED_W-1:0]  carga_s;
  logic [CRED_W-1:0]  sobra_s;
  logic               expira_s;

`ifdef RECARGA_TIMEOUT_EN
  recarga_timer #(
    .CICLOS (TIMEOUT_CICLOS)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .ativo_i  (estado_q == COLETA),
    .evento_i (bus.moeda | bus.confirma | bus.cancela),
    .expira_o (expira_s)
  );
`else
  assign expira_s = 1'b0;
`endif

  // Next state and next registered outputs; refund_q holds coins still owed after the current one.
  always_comb begin
    estado_d   = estado_q;
    credito_d  = credito_q;
    refund_d   = refund_q;
    carrega1_d = 2'd0;
    carrega2_d = 2'd0;
    devolve_d  = 1'b0;
    rejeita_d  = 1'b0;
    ocupado_d  = 1'b0;

    saldo_sel_s = bus.sel_passageiro ? bus.saldo2 : bus.saldo1;
    carga_s     = min_carga(credito_q, saldo_sel_s);
    sobra_s     = credito_q - carga_s;

    case (estado_q)
      IDLE: begin
        if (bus.moeda) begin
          estado_d  = COLETA;
          credito_d = 2'd1;
        end else begin
          estado_d  = IDLE;
        end
      end

      COLETA: begin
        if (bus.cancela || expira_s) begin
          estado_d  = TROCO;
          credito_d = 2'd0;
          refund_d  = credito_q - 2'd1;
          devolve_d = 1'b1;
          ocupado_d = 1'b1;
          rejeita_d = bus.moeda;
        end else if (bus.confirma) begin
          credito_d = 2'd0;
          ocupado_d = 1'b1;
          rejeita_d = bus.moeda;
          if (carga_s == 2'd0) begin
            // Card already full: skip the load cycle and start refunding at once.
            estado_d  = TROCO;
            refund_d  = sobra_s - 2'd1;
            devolve_d = 1'b1;
          end else begin
            estado_d = CARREGA;
            refund_d = sobra_s;
            if (bus.sel_passageiro) begin
              carrega2_d = carga_s;
            end else begin
              carrega1_d = carga_s;
            end
          end
        end else if (bus.moeda) begin
          if (credito_q == MAX_CREDITO) begin
            rejeita_d = 1'b1;
          end else begin
            credito_d = credito_q + 2'd1;
          end
        end else begin
          estado_d = COLETA;
        end
      end

      CARREGA, TROCO: begin
        rejeita_d = bus.moeda;
        if (refund_q != 2'd0) begin
          estado_d  = TROCO;
          refund_d  = refund_q - 2'd1;
          devolve_d = 1'b1;
          ocupado_d = 1'b1;
        end else begin
          estado_d  = IDLE;
        end
      end

      default: begin
        estado_d  = IDLE;
        credito_d = 2'd0;
        refund_d  = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= IDLE;
      credito_q  <= 2'd0;
      refund_q   <= 2'd0;
      carrega1_q <= 2'd0;
      carrega2_q <= 2'd0;
      devolve_q  <= 1'b0;
      rejeita_q  <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      credito_q  <= credito_d;
      refund_q   <= refund_d;
      carrega1_q <= carrega1_d;
      carrega2_q <= carrega2_d;
      devolve_q  <= devolve_d;
      rejeita_q  <= rejeita_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.carrega1 = carrega1_q;
  assign bus.carrega2 = carrega2_q;
  assign bus.devolve  = devolve_q;
  assign bus.credito  = credito_q;
  assign bus.rejeita  = rejeita_q;
  assign bus.ocupado  = ocupado_q;

endmodule

// File: tb/tb_recarga_terminal.sv
// Bench for recarga_terminal: directed scenarios plus random stimulus against a
// transaction-level model that schedules each commit's output cycles in a queue.
module tb_recarga_terminal;

  logic clock;
  logic reset;

  recarga_terminal_if bus();

  recarga_terminal dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       m;
    logic       s;
    logic       cf;
    logic       cn;
    logic [2:0] s1;
    logic [2:0] s2;
  } stim_t;

  typedef struct {
    int c1;
    int c2;
    bit dev;
  } item_t;

  // Model: credit being collected, plus the queue of output cycles a commit still owes.
  int         m_cred;
  bit         m_col;
  bit         m_prev_ocup;
  int         m_idle;
  item_t      pend[$];
  logic [8:0] exp_v;

  function automatic stim_t S(input bit m, input bit s, input bit cf, input bit cn,
                              input int s1, input int s2);
    stim_t t;
    t.m  = m;
    t.s  = s;
    t.cf = cf;
    t.cn = cn;
    t.s1 = 3'(s1);
    t.s2 = 3'(s2);
    return t;
  endfunction

  function automatic stim_t IDL();
    return S(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t COIN();
    return S(1, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t CANC();
    return S(0, 0, 0, 1, 0, 0);
  endfunction

  function automatic logic [8:0] obs_v();
    return {bus.credito, bus.carrega1, bus.carrega2, bus.devolve, bus.rejeita, bus.ocupado};
  endfunction

  function automatic void model_reset();
    m_cred      = 0;
    m_col       = 1'b0;
    m_prev_ocup = 1'b0;
    m_idle      = 0;
    pend.delete();
    exp_v       = 9'd0;
  endfunction

  function automatic void model_step(input stim_t t);
    int    c1 = 0, c2 = 0, bal, room, load, refund;
    bit    dev = 0, rej = 0, ocup = 0, to = 0;
    item_t it;
    if (m_prev_ocup) begin
      rej = t.m;
      if (pend.size() > 0) begin
        it = pend.pop_front();
        c1 = it.c1; c2 = it.c2; dev = it.dev; ocup = 1;
      end
    end else if (!m_col) begin
      if (t.m) begin
        m_col = 1; m_cred = 1; m_idle = 0;
      end
    end else begin
      if (t.m || t.cf || t.cn) m_idle = 0;
      else m_idle++;
`ifdef RECARGA_TIMEOUT_EN
      to = (m_idle == 10);
`endif
      if (t.cn || t.cf || to) begin
        rej = t.m;
        if (t.cn || to) begin
          load   = 0;
          refund = m_cred;
        end else begin
          bal    = t.s ? int'(t.s2) : int'(t.s1);
          if (bal > 5) bal = 5;
          room   = 5 - bal;
          load   = (m_cred < room) ? m_cred : room;
          refund = m_cred - load;
        end
        if (load > 0) pend.push_back('{t.s ? 0 : load, t.s ? load : 0, 1'b0});
        repeat (refund) pend.push_back('{0, 0, 1'b1});
        m_cred = 0; m_col = 0;
        it = pend.pop_front();
        c1 = it.c1; c2 = it.c2; dev = it.dev; ocup = 1;
      end else if (t.m) begin
        if (m_cred == 3) rej = 1;
        else m_cred++;
      end
    end
    m_prev_ocup = ocup;
    exp_v = {2'(m_cred), 2'(c1), 2'(c2), dev, rej, ocup};
  endfunction

  task automatic cyc(input stim_t t);
    bus.moeda          = t.m;
    bus.sel_passageiro = t.s;
    bus.confirma       = t.cf;
    bus.cancela        = t.cn;
    bus.saldo1         = t.s1;
    bus.saldo2         = t.s2;
    model_step(t);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cyc(IDL());
    reset = 1'b0;
    #2;
    vectors++;
    if (obs_v() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_initial: got %b want %b", obs_v(), 9'd0);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(COIN());
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL reset_coin%0d: got %b want %b", i, obs_v(), exp_v);
      end
    end
    bus.moeda = 1'b0;
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (obs_v() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %b want %b", obs_v(), 9'd0);
    end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(COIN());
    vectors++;
    if (obs_v() !== exp_v || bus.credito !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_release_coin: got %b want %b", obs_v(), exp_v);
    end
  endtask

  task automatic test_carga_cheia();
    stim_t st[$];
    st = '{CANC(), IDL(), IDL(), IDL(), IDL(), COIN(), COIN(), COIN(),
           S(0, 0, 1, 0, 0, 0), IDL()};
    foreach (st[i]) begin
      cyc(st[i]);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL carga_cheia step%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i == 8) begin
        vectors++;
        if (bus.carrega1 !== 2'd3 || bus.carrega2 !== 2'd0 || bus.ocupado !== 1'b1) begin
          miscompares++;
          $display("FAIL carga_cheia_load: got c1=%0d c2=%0d oc=%b want 3 0 1",
                   bus.carrega1, bus.carrega2, bus.ocupado);
        end
      end
      if (i == 9) begin
        vectors++;
        if (bus.carrega1 !== 2'd0 || bus.devolve !== 1'b0 || bus.ocupado !== 1'b0) begin
          miscompares++;
          $display("FAIL carga_cheia_after: got c1=%0d dev=%b oc=%b want 0 0 0",
                   bus.carrega1, bus.devolve, bus.ocupado);
        end
      end
    end
  endtask

  task automatic test_clip();
    stim_t st[$];
    st = '{CANC(), IDL(), IDL(), IDL(), IDL(), COIN(), COIN(), COIN(),
           S(0, 1, 1, 0, 0, 4), IDL(), IDL(), IDL()};
    foreach (st[i]) begin
      cyc(st[i]);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL clip step%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i == 8) begin
        vectors++;
        if (bus.carrega2 !== 2'd1 || bus.carrega1 !== 2'd0 || bus.devolve !== 1'b0) begin
          miscompares++;
          $display("FAIL clip_load: got c2=%0d c1=%0d dev=%b want 1 0 0",
                   bus.carrega2, bus.carrega1, bus.devolve);
        end
      end
      if (i >= 9) begin
        vectors++;
        if (bus.devolve !== (i < 11)) begin
          miscompares++;
          $display("FAIL clip_refund step%0d: got dev=%b want %b", i, bus.devolve, (i < 11));
        end
      end
    end
  endtask

  task automatic test_rejeita_cancela();
    stim_t st[$];
    st = '{CANC(), IDL(), IDL(), IDL(), IDL(), COIN(), COIN(), COIN(), COIN(),
           CANC(), IDL(), IDL(), IDL()};
    foreach (st[i]) begin
      cyc(st[i]);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL rejeita_cancela step%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i == 8) begin
        vectors++;
        if (bus.credito !== 2'd3 || bus.rejeita !== 1'b1) begin
          miscompares++;
          $display("FAIL rejeita_full: got cred=%0d rej=%b want 3 1", bus.credito, bus.rejeita);
        end
      end
      if (i >= 9) begin
        vectors++;
        if (bus.devolve !== (i < 12) || bus.credito !== 2'd0) begin
          miscompares++;
          $display("FAIL rejeita_refund step%0d: got dev=%b cred=%0d want %b 0",
                   i, bus.devolve, bus.credito, (i < 12));
        end
      end
    end
  endtask

  task automatic test_saldo_cheio();
    stim_t st[$];
    st = '{CANC(), IDL(), IDL(), IDL(), IDL(), COIN(), COIN(),
           S(0, 0, 1, 0, 5, 0), IDL(), IDL(),
           COIN(), S(1, 0, 1, 1, 0, 0), IDL(),
           COIN(), S(0, 0, 1, 0, 7, 0), IDL()};
    foreach (st[i]) begin
      cyc(st[i]);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL saldo_cheio step%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i == 7 || i == 8 || i == 14) begin
        vectors++;
        if (bus.devolve !== 1'b1 || bus.carrega1 !== 2'd0) begin
          miscompares++;
          $display("FAIL saldo_cheio_refund step%0d: got dev=%b c1=%0d want 1 0",
                   i, bus.devolve, bus.carrega1);
        end
      end
      if (i == 11) begin
        vectors++;
        if (bus.rejeita !== 1'b1 || bus.devolve !== 1'b1 || bus.carrega1 !== 2'd0) begin
          miscompares++;
          $display("FAIL prioridade: got rej=%b dev=%b c1=%0d want 1 1 0",
                   bus.rejeita, bus.devolve, bus.carrega1);
        end
      end
    end
  endtask

  task automatic test_timeout();
    stim_t st[$];
    st = '{CANC(), IDL(), IDL(), IDL(), IDL(), COIN()};
    repeat (10) st.push_back(IDL());
    st.push_back(IDL());
    foreach (st[i]) begin
      cyc(st[i]);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL timeout step%0d: got %b want %b", i, obs_v(), exp_v);
      end
      if (i == 15) begin
        vectors++;
`ifdef RECARGA_TIMEOUT_EN
        if (bus.devolve !== 1'b1 || bus.credito !== 2'd0) begin
          miscompares++;
          $display("FAIL timeout_fire: got dev=%b cred=%0d want 1 0", bus.devolve, bus.credito);
        end
`else
        if (bus.devolve !== 1'b0 || bus.credito !== 2'd1 || bus.ocupado !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_hold: got dev=%b cred=%0d oc=%b want 0 1 0",
                   bus.devolve, bus.credito, bus.ocupado);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    stim_t t;
    for (int i = 0; i < 600; i++) begin
      t = S($urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      cyc(t);
      vectors++;
      if (obs_v() !== exp_v) begin
        miscompares++;
        $display("FAIL random step%0d: got %b want %b", i, obs_v(), exp_v);
      end
    end
  endtask

  initial begin
    reset              = 1'b0;
    bus.moeda          = 1'b0;
    bus.sel_passageiro = 1'b0;
    bus.confirma       = 1'b0;
    bus.cancela        = 1'b0;
    bus.saldo1         = 3'd0;
    bus.saldo2         = 3'd0;
    model_reset();
    test_reset();
    test_carga_cheia();
    test_clip();
    test_rejeita_cancela();
    test_saldo_cheio();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
